// File: rtl/scan_test_sequencer.sv
// -----------------------------------------------------------------------------
// scan_test_sequencer
//
// Sequences full-scan test of one scan-inserted core. Each vector goes through
// one serial scan-in, one functional capture and one serial scan-out. The
// response is then compared with the expected values, and a pass/fail strobe
// is issued. A saturating fail counter covers the whole session.
//
// Ports
//   CK         clock shared with the core
//   RST        synchronous reset, active-high
//   START      begin a session (only honoured while idle)
//   VEC_VALID  vector offered by the source
//   VEC_READY  sequencer will take the offered vector on this edge
//   VEC_LAST   offered vector closes the session
//   VEC_SI     scan-in data, bit k shifted in during shift-in cycle k
//   VEC_PI     primary input values applied for capture
//   EXP_SO     expected scan-out, bit k = SO in shift-out cycle k
//   EXP_PO     expected primary outputs at capture
//   SE         core scan enable
//   SI         core scan-in
//   PI         core primary inputs
//   CORE_CE    core clock enable
//   SO         core scan-out (combinational from the last chain flop)
//   PO         core primary outputs
//   RES_VALID  one-cycle result strobe
//   RES_FAIL   vector mismatched, qualified by RES_VALID
//   FAIL_CNT   failing vectors this session, saturating
//   BUSY       high in every state except IDLE
//   DONE       one-cycle end-of-session pulse
//
// All outputs come straight from flops. Each output flop is loaded with the
// value that the *next* state needs, so the core sees SE/SI/CORE_CE aligned
// with the state it is in.
// -----------------------------------------------------------------------------
module scan_test_sequencer #(
    parameter int CHAIN_LEN = 3,
    parameter int PI_WIDTH  = 4,
    parameter int PO_WIDTH  = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 VEC_VALID,
    output logic                 VEC_READY,
    input  logic                 VEC_LAST,
    input  logic [CHAIN_LEN-1:0] VEC_SI,
    input  logic [PI_WIDTH-1:0]  VEC_PI,
    input  logic [CHAIN_LEN-1:0] EXP_SO,
    input  logic [PO_WIDTH-1:0]  EXP_PO,
    output logic                 SE,
    output logic                 SI,
    output logic [PI_WIDTH-1:0]  PI,
    output logic                 CORE_CE,
    input  logic                 SO,
    input  logic [PO_WIDTH-1:0]  PO,
    output logic                 RES_VALID,
    output logic                 RES_FAIL,
    output logic [CNT_WIDTH-1:0] FAIL_CNT,
    output logic                 BUSY,
    output logic                 DONE
);

    // Bit counter is wide enough to index every chain position (min 1 bit).
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd4;
    localparam logic [2:0] ST_RESULT    = 3'd5;

    // Saturating increment: the counter sticks at all-ones rather than wrap.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    // Vector verdict: any scan-out bit or any captured PO differing fails it.
    function automatic logic vec_mismatch(
        input logic [CHAIN_LEN-1:0] resp,
        input logic [CHAIN_LEN-1:0] exp_so,
        input logic [PO_WIDTH-1:0]  po,
        input logic [PO_WIDTH-1:0]  exp_po
    );
        return (resp != exp_so) || (po != exp_po);
    endfunction

    // Control state
    logic [2:0]           state_q,     state_d;
    logic [CW-1:0]        bit_cnt_q,   bit_cnt_d;

    // Latched vector and collected response
    logic [CHAIN_LEN-1:0] si_sh_q,     si_sh_d;
    logic [CHAIN_LEN-1:0] exp_so_q,    exp_so_d;
    logic [PO_WIDTH-1:0]  exp_po_q,    exp_po_d;
    logic                 last_q,      last_d;
    logic [PO_WIDTH-1:0]  po_q,        po_d;
    logic [CHAIN_LEN-1:0] resp_q,      resp_d;

    // Output flops
    logic                 se_q,        se_d;
    logic                 si_q,        si_d;
    logic [PI_WIDTH-1:0]  pi_q,        pi_d;
    logic                 ce_q,        ce_d;
    logic                 ready_q,     ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_fail_q,  res_fail_d;
    logic [CNT_WIDTH-1:0] fail_cnt_q,  fail_cnt_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        si_sh_d     = si_sh_q;
        exp_so_d    = exp_so_q;
        exp_po_d    = exp_po_q;
        last_d      = last_q;
        po_d        = po_q;
        resp_d      = resp_q;
        se_d        = se_q;
        si_d        = si_q;
        pi_d        = pi_q;
        ce_d        = ce_q;
        ready_d     = ready_q;
        res_valid_d = 1'b0;
        res_fail_d  = 1'b0;
        fail_cnt_d  = fail_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                se_d = 1'b0;
                si_d = 1'b0;
                ce_d = 1'b0;
                if (START) begin
                    state_d    = ST_LOAD;
                    ready_d    = 1'b1;
                    fail_cnt_d = {CNT_WIDTH{1'b0}};
                end else begin
                    ready_d = 1'b0;
                end
            end

            ST_LOAD: begin
                if (VEC_VALID && ready_q) begin
                    // Bit 0 goes out on the first shift-in cycle; the rest
                    // are queued in si_sh and shifted down one per cycle.
                    state_d   = ST_SHIFT_IN;
                    bit_cnt_d = {CW{1'b0}};
                    si_sh_d   = VEC_SI >> 1;
                    exp_so_d  = EXP_SO;
                    exp_po_d  = EXP_PO;
                    last_d    = VEC_LAST;
                    pi_d      = VEC_PI;
                    si_d      = VEC_SI[0];
                    se_d      = 1'b1;
                    ce_d      = 1'b1;
                    ready_d   = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_SHIFT_IN: begin
                if (bit_cnt_q == LAST_IDX) begin
                    state_d   = ST_CAPTURE;
                    bit_cnt_d = {CW{1'b0}};
                    se_d      = 1'b0;
                    si_d      = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    si_d      = si_sh_q[0];
                    si_sh_d   = si_sh_q >> 1;
                end
            end

            ST_CAPTURE: begin
                // PO reflects the scanned-in state before the capture edge.
                po_d      = PO;
                state_d   = ST_SHIFT_OUT;
                bit_cnt_d = {CW{1'b0}};
                se_d      = 1'b1;
                si_d      = 1'b0;
                ce_d      = 1'b1;
            end

            ST_SHIFT_OUT: begin
                // SO is sampled before the core shifts, so resp[0] holds the
                // last chain flop.
                resp_d[bit_cnt_q] = SO;
                if (bit_cnt_q == LAST_IDX) begin
                    state_d     = ST_RESULT;
                    bit_cnt_d   = {CW{1'b0}};
                    se_d        = 1'b0;
                    ce_d        = 1'b0;
                    res_valid_d = 1'b1;
                    res_fail_d  = vec_mismatch(resp_d, exp_so_q, po_q, exp_po_q);
                    done_d      = last_q;
                    if (res_fail_d) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end else begin
                        fail_cnt_d = fail_cnt_q;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            ST_RESULT: begin
                se_d = 1'b0;
                si_d = 1'b0;
                ce_d = 1'b0;
                if (last_q) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_LOAD;
                    ready_d = 1'b1;
                end
            end

            default: begin
                // Unreachable encoding: park safely with the core frozen.
                state_d   = ST_IDLE;
                bit_cnt_d = {CW{1'b0}};
                se_d      = 1'b0;
                si_d      = 1'b0;
                ce_d      = 1'b0;
                ready_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; RST drops any in-flight vector silently.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {CW{1'b0}};
            si_sh_q     <= {CHAIN_LEN{1'b0}};
            exp_so_q    <= {CHAIN_LEN{1'b0}};
            exp_po_q    <= {PO_WIDTH{1'b0}};
            last_q      <= 1'b0;
            po_q        <= {PO_WIDTH{1'b0}};
            resp_q      <= {CHAIN_LEN{1'b0}};
            se_q        <= 1'b0;
            si_q        <= 1'b0;
            pi_q        <= {PI_WIDTH{1'b0}};
            ce_q        <= 1'b0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_fail_q  <= 1'b0;
            fail_cnt_q  <= {CNT_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            si_sh_q     <= si_sh_d;
            exp_so_q    <= exp_so_d;
            exp_po_q    <= exp_po_d;
            last_q      <= last_d;
            po_q        <= po_d;
            resp_q      <= resp_d;
            se_q        <= se_d;
            si_q        <= si_d;
            pi_q        <= pi_d;
            ce_q        <= ce_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_fail_q  <= res_fail_d;
            fail_cnt_q  <= fail_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign VEC_READY = ready_q;
    assign SE        = se_q;
    assign SI        = si_q;
    assign PI        = pi_q;
    assign CORE_CE   = ce_q;
    assign RES_VALID = res_valid_q;
    assign RES_FAIL  = res_fail_q;
    assign FAIL_CNT  = fail_cnt_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_scan_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_test_sequencer
//
// Bench for scan_test_sequencer with a 3-flop scan core model attached.
// Expected results come from a functional reference (scan-in order, capture
// function, scan-out order) and go into a scoreboard queue when a vector is
// accepted. An independent monitor pops them whenever RES_VALID is seen.
// -----------------------------------------------------------------------------
module tb_scan_test_sequencer;

    localparam int N   = 3;
    localparam int PIW = 4;
    localparam int POW = 1;
    localparam int CW  = 8;

    logic           CK = 1'b0;
    logic           RST, START, VEC_VALID, VEC_LAST;
    logic [N-1:0]   VEC_SI, EXP_SO;
    logic [PIW-1:0] VEC_PI;
    logic [POW-1:0] EXP_PO;
    logic           VEC_READY, SE, SI, CORE_CE, RES_VALID, RES_FAIL, BUSY, DONE;
    logic [PIW-1:0] PI;
    logic [CW-1:0]  FAIL_CNT;
    logic           SO;
    logic [POW-1:0] PO;

    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    scan_test_sequencer #(
        .CHAIN_LEN(N), .PI_WIDTH(PIW), .PO_WIDTH(POW), .CNT_WIDTH(CW)
    ) dut (
        .CK(CK), .RST(RST), .START(START),
        .VEC_VALID(VEC_VALID), .VEC_READY(VEC_READY), .VEC_LAST(VEC_LAST),
        .VEC_SI(VEC_SI), .VEC_PI(VEC_PI), .EXP_SO(EXP_SO), .EXP_PO(EXP_PO),
        .SE(SE), .SI(SI), .PI(PI), .CORE_CE(CORE_CE), .SO(SO), .PO(PO),
        .RES_VALID(RES_VALID), .RES_FAIL(RES_FAIL), .FAIL_CNT(FAIL_CNT),
        .BUSY(BUSY), .DONE(DONE)
    );

    // ---------------- core model: shift chain plus functional logic ----------
    function automatic logic [N-1:0] core_next(input logic [N-1:0] s, input logic [PIW-1:0] p);
        return {s[1] ^ p[3], (s[0] & p[2]) | p[1], s[2] ^ p[0]};
    endfunction

    function automatic logic [POW-1:0] core_po(input logic [N-1:0] s, input logic [PIW-1:0] p);
        return POW'((s[2] ^ s[0]) ^ (p[1] & p[3]) ^ (s[1] & p[0]));
    endfunction

    logic [N-1:0] core_q = '0;
    always @(posedge CK) begin
        if (CORE_CE) core_q <= SE ? {core_q[N-2:0], SI} : core_next(core_q, PI);
    end
    assign SO = core_q[N-1];
    assign PO = core_po(core_q, PI);

    // ---------------- reference: what a correct scan test must observe -------
    // First bit shifted in travels furthest, ending in the last flop.
    function automatic logic [N-1:0] load_state(input logic [N-1:0] si);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) s[i] = si[N-1-i];
        return s;
    endfunction

    function automatic logic [N-1:0] ref_so(input logic [N-1:0] si, input logic [PIW-1:0] p);
        logic [N-1:0] cap, r;
        cap = core_next(load_state(si), p);
        for (int k = 0; k < N; k++) r[k] = cap[N-1-k];
        return r;
    endfunction

    function automatic logic [POW-1:0] ref_po(input logic [N-1:0] si, input logic [PIW-1:0] p);
        return core_po(load_state(si), p);
    endfunction

    typedef struct {
        logic          fail;
        logic [CW-1:0] cnt;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: scoreboard pop and handshake spacing ----------
    int cyc = 0;
    bit gap_chk = 1'b0;
    int last_ready = -1;
    int ready_cnt = 0;

    always @(negedge CK) begin : monitor
        exp_t e;
        cyc++;
        if (RES_VALID) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_res_valid", 32'(RES_VALID), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("res_fail", 32'(RES_FAIL), 32'(e.fail));
                chk("fail_cnt", 32'(FAIL_CNT), 32'(e.cnt));
                chk("done", 32'(DONE), 32'(e.done));
            end
        end else if (DONE) begin
            chk("done_without_result", 32'(DONE), 32'd0);
        end
        if (VEC_READY) begin
            chk("ce_in_load", 32'(CORE_CE), 32'd0);
            if (gap_chk) begin
                ready_cnt++;
                if (last_ready >= 0) chk("ready_spacing", 32'(cyc - last_ready), 32'd9);
                last_ready = cyc;
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic start_session();
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        model_cnt = 0;
        chk("busy_after_start", 32'(BUSY), 32'd1);
    endtask

    // Returns at the falling edge of the first cycle after the handshake edge.
    task automatic send_vec(input logic [N-1:0] si, input logic [PIW-1:0] p,
                            input logic [N-1:0] eso, input logic [POW-1:0] epo,
                            input logic last, input bit push, input bit hold);
        exp_t e;
        int   waited = 0;
        VEC_SI = si; VEC_PI = p; EXP_SO = eso; EXP_PO = epo; VEC_LAST = last;
        VEC_VALID = 1'b1;
        while (!VEC_READY && waited < 40) begin
            @(negedge CK);
            waited++;
        end
        if (!VEC_READY) begin
            chk("handshake_timeout", 32'(VEC_READY), 32'd1);
            VEC_VALID = 1'b0;
        end else begin
            if (push) begin
                e.fail = (eso != ref_so(si, p)) || (epo != ref_po(si, p));
                if (e.fail && model_cnt < 255) model_cnt++;
                e.cnt  = CW'(model_cnt);
                e.done = last;
                sb_q.push_back(e);
            end
            @(negedge CK);
            if (!hold) VEC_VALID = 1'b0;
        end
    endtask

    // Cycle-by-cycle view of one vector, j = cycles after the handshake edge.
    task automatic check_timeline(input logic [N-1:0] si, input logic [PIW-1:0] p,
                                  input logic last, input bit pulse_start);
        for (int j = 1; j <= 2*N+3; j++) begin
            if (j > 1) @(negedge CK);
            if (pulse_start) START = (j == 2);
            chk("tl_se", 32'(SE), 32'((j <= N) || (j >= N+2 && j <= 2*N+1)));
            chk("tl_si", 32'(SI), 32'((j <= N) ? si[j-1] : 1'b0));
            chk("tl_ce", 32'(CORE_CE), 32'(j <= 2*N+1));
            chk("tl_res_valid", 32'(RES_VALID), 32'(j == 2*N+2));
            chk("tl_ready", 32'(VEC_READY), 32'(j == 2*N+3 && !last));
            chk("tl_busy", 32'(BUSY), 32'(j <= 2*N+2 || !last));
            if (j == 1) chk("tl_pi", 32'(PI), 32'(p));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_se"},        32'(SE),        32'd0);
        chk({tag, "_si"},        32'(SI),        32'd0);
        chk({tag, "_pi"},        32'(PI),        32'd0);
        chk({tag, "_ce"},        32'(CORE_CE),   32'd0);
        chk({tag, "_ready"},     32'(VEC_READY), 32'd0);
        chk({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
        chk({tag, "_res_fail"},  32'(RES_FAIL),  32'd0);
        chk({tag, "_fail_cnt"},  32'(FAIL_CNT),  32'd0);
        chk({tag, "_busy"},      32'(BUSY),      32'd0);
        chk({tag, "_done"},      32'(DONE),      32'd0);
    endtask

    // ---------------- stimulus ------------------------------------------------
    initial begin : stimulus
        logic [N-1:0]   si, eso;
        logic [PIW-1:0] p;
        logic [POW-1:0] epo;
        int             mode;

        RST = 1'b1; START = 1'b0; VEC_VALID = 1'b0; VEC_LAST = 1'b0;
        VEC_SI = '0; VEC_PI = '0; EXP_SO = '0; EXP_PO = '0;
        repeat (3) @(negedge CK);
        chk_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CK);

        // Passing vector 101 / A, then same vector with SO bit1 flipped, last.
        start_session();
        send_vec(3'b101, 4'hA, ref_so(3'b101, 4'hA), ref_po(3'b101, 4'hA), 1'b0, 1'b1, 1'b0);
        check_timeline(3'b101, 4'hA, 1'b0, 1'b0);
        send_vec(3'b101, 4'hA, ref_so(3'b101, 4'hA) ^ 3'b010, ref_po(3'b101, 4'hA), 1'b1, 1'b1, 1'b0);
        check_timeline(3'b101, 4'hA, 1'b1, 1'b0);
        repeat (3) @(negedge CK);
        chk("cnt_hold_idle", 32'(FAIL_CNT), 32'd1);

        // VEC_VALID held in IDLE without START: nothing may be taken.
        VEC_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            chk("idle_ready", 32'(VEC_READY), 32'd0);
            chk("idle_busy", 32'(BUSY), 32'd0);
        end
        VEC_VALID = 1'b0;
        @(negedge CK);

        // START pulsed during SHIFT_IN must not disturb the vector.
        start_session();
        send_vec(3'b011, 4'h5, ref_so(3'b011, 4'h5), ref_po(3'b011, 4'h5), 1'b1, 1'b1, 1'b0);
        check_timeline(3'b011, 4'h5, 1'b1, 1'b1);
        START = 1'b0;

        // PO-only mismatch; CE low between vectors is checked by the timeline.
        start_session();
        send_vec(3'b110, 4'h3, ref_so(3'b110, 4'h3), ref_po(3'b110, 4'h3), 1'b0, 1'b1, 1'b0);
        check_timeline(3'b110, 4'h3, 1'b0, 1'b0);
        send_vec(3'b001, 4'hC, ref_so(3'b001, 4'hC), ~ref_po(3'b001, 4'hC), 1'b1, 1'b1, 1'b0);
        check_timeline(3'b001, 4'hC, 1'b1, 1'b0);

        // Reset during SHIFT_OUT of vector 1, then a clean new session.
        start_session();
        send_vec(3'b100, 4'h9, ~ref_so(3'b100, 4'h9), ref_po(3'b100, 4'h9), 1'b0, 1'b1, 1'b0);
        check_timeline(3'b100, 4'h9, 1'b0, 1'b0);
        send_vec(3'b010, 4'h6, ref_so(3'b010, 4'h6), ref_po(3'b010, 4'h6), 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge CK);
        chk("in_shift_out_se", 32'(SE), 32'd1);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        chk_reset_outputs("midrst");
        repeat (15) @(negedge CK);
        start_session();
        send_vec(3'b111, 4'h1, ref_so(3'b111, 4'h1) ^ 3'b100, ref_po(3'b111, 4'h1), 1'b1, 1'b1, 1'b0);
        check_timeline(3'b111, 4'h1, 1'b1, 1'b0);

        // 300 back-to-back failing vectors with VEC_VALID held high.
        gap_chk = 1'b1; ready_cnt = 0; last_ready = -1;
        start_session();
        for (int i = 0; i < 300; i++) begin
            si = N'($urandom);
            p  = PIW'($urandom);
            send_vec(si, p, ref_so(si, p) ^ 3'b001, ref_po(si, p), 1'(i == 299), 1'b1, i != 299);
        end
        repeat (2*N+3) @(negedge CK);
        gap_chk = 1'b0;
        chk("ready_count", 32'(ready_cnt), 32'd300);
        chk("fail_cnt_sat", 32'(FAIL_CNT), 32'hFF);
        chk("busy_after_sat", 32'(BUSY), 32'd0);

        // Random session with random gaps and random corruption.
        start_session();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CK);
            si   = N'($urandom);
            p    = PIW'($urandom);
            eso  = ref_so(si, p);
            epo  = ref_po(si, p);
            mode = int'($urandom_range(0, 2));
            if (mode == 1) eso = eso ^ N'($urandom_range(1, 7));
            else if (mode == 2) epo = ~epo;
            send_vec(si, p, eso, epo, 1'(i == 39), 1'b1, 1'b0);
        end
        repeat (2*N+6) @(negedge CK);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
